// File: rtl/dilated_conv_k4_mac_if.sv
// Tap-vector input, weight write port and result output of the k=4 dilated conv MAC.
// master drives taps/weights and consumes results; slave is the MAC unit.
interface dilated_conv_k4_mac_if #(
   parameter int W = 16
);
   logic        [3:0][W-1:0] taps;
   logic                     in_valid;
   logic                     in_ready;
   logic                     w_wr_en;
   logic              [2:0]  w_addr;
   logic signed     [W-1:0]  w_data;
   logic signed     [W-1:0]  out_data;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output taps, in_valid, w_wr_en, w_addr, w_data, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  taps, in_valid, w_wr_en, w_addr, w_data, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/dilated_conv_k4_mac.sv
// k=4 dilated causal conv tap unit: y = bias + sum(w[k]*tap[k]), one multiply per cycle, rounded and saturated.
// Result valid 5 cycles after the input handshake; holds in OUT until out_ready, in_ready only while IDLE.
module dilated_conv_k4_mac #(
   parameter int W    = 16,
   parameter int FRAC = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   dilated_conv_k4_mac_if.slave bus
);
   localparam int ACCW = 2*W + 3;
   localparam logic signed [ACCW-1:0] HALF = ACCW'(1) <<< (FRAC-1);
   localparam logic signed [W-1:0]    OMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]    OMIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                  state, state_nxt;
   logic signed [W-1:0]     taps_q [4];
   logic signed [W-1:0]     w_q    [4];
   logic signed [W-1:0]     bias_q;
   logic signed [ACCW-1:0]  acc;
   logic        [1:0]       idx;
   logic signed [W-1:0]     out_data_q;
   logic                    out_valid_q;
   logic signed [2*W-1:0]   prod;
   logic signed [ACCW-1:0]  rsum;
   logic signed [ACCW-1:0]  rshift;

   assign prod   = taps_q[idx] * w_q[idx];
   assign rsum   = acc + HALF;
   assign rshift = rsum >>> FRAC;

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_nxt = MAC;
         MAC:     if (idx == 2'd3)   state_nxt = ROUND;
         ROUND:                      state_nxt = OUT;
         OUT:     if (bus.out_ready) state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            taps_q[k] <= '0;
            w_q[k]    <= '0;
         end
         bias_q      <= '0;
         acc         <= '0;
         idx         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         // Coefficients only change between vectors so a running MAC sees a consistent set.
         if (state == IDLE && bus.w_wr_en) begin
            case (bus.w_addr)
               3'd0, 3'd1, 3'd2, 3'd3: w_q[bus.w_addr[1:0]] <= bus.w_data;
               3'd4:                   bias_q <= bus.w_data;
               default: ;
            endcase
         end
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int k = 0; k < 4; k++) taps_q[k] <= bus.taps[k];
                  acc <= {{(W+3){bias_q[W-1]}}, bias_q} <<< FRAC;
                  idx <= '0;
               end
            end
            MAC: begin
               acc <= acc + ACCW'(prod);
               idx <= idx + 2'd1;
            end
            ROUND: begin
               if (rshift > ACCW'(OMAX))      out_data_q <= OMAX;
               else if (rshift < ACCW'(OMIN)) out_data_q <= OMIN;
               else                           out_data_q <= rshift[W-1:0];
               out_valid_q <= 1'b1;
            end
            OUT: begin
               if (bus.out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dilated_conv_k4_mac.sv
// Randomised bench for dilated_conv_k4_mac against an integer reference of bias + sum(w*tap), round, saturate.
module tb_dilated_conv_k4_mac;
   localparam int W    = 16;
   localparam int FRAC = 12;

   logic clk = 1'b0;
   logic rst;

   dilated_conv_k4_mac_if #(.W(W)) bus ();

   dilated_conv_k4_mac #(.W(W), .FRAC(FRAC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int mw [4];
   int mb;

   function automatic int rnd16();
      return int'($signed(16'($urandom)));
   endfunction

   function automatic int ref_y(input int t [4]);
      longint acc;
      acc = longint'(mb) * (longint'(1) << FRAC);
      for (int k = 0; k < 4; k++) acc += longint'(t[k]) * longint'(mw[k]);
      acc = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
      if (acc > 32767)  return 32767;
      if (acc < -32768) return -32768;
      return int'(acc);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int a, input int v);
      bus.w_wr_en = 1'b1;
      bus.w_addr  = 3'(a);
      bus.w_data  = 16'(v);
      tick();
      bus.w_wr_en = 1'b0;
      if (a < 4)       mw[a] = v;
      else if (a == 4) mb    = v;
   endtask

   task automatic set_all(input int w0, input int w1, input int w2, input int w3, input int b);
      set_w(0, w0); set_w(1, w1); set_w(2, w2); set_w(3, w3); set_w(4, b);
   endtask

   task automatic start_vec(input int t [4]);
      int n = 0;
      while (!bus.in_ready && n < 30) begin tick(); n++; end
      for (int k = 0; k < 4; k++) bus.taps[k] = 16'(t[k]);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      // Scramble taps so any late sampling shows up as a wrong result.
      for (int k = 0; k < 4; k++) bus.taps[k] = 16'($urandom);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 30) begin tick(); lat++; end
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic run_vec(input int t [4], output int y, output int lat);
      start_vec(t);
      wait_out(lat);
      y = int'($signed(bus.out_data));
      accept();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      mw = '{0, 0, 0, 0};
      mb = 0;
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      else passed++;
      total++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      else passed++;
      total++;
      if (bus.out_data !== 16'sd0) $display("FAIL reset_out_data: got %0d want 0", bus.out_data);
      else passed++;
   endtask

   task automatic test_zero_weights();
      int t [4];
      int y, lat;
      t = '{1000, -1000, 7, 9};
      run_vec(t, y, lat);
      total++;
      if (y !== 0 || lat != 5) $display("FAIL zero_weights: got %0d lat %0d, want 0 lat 5", y, lat);
      else passed++;
   endtask

   task automatic test_single_tap();
      int t [4];
      int y, lat;
      t = '{100, 200, 300, 400};
      set_all(4096, 0, 0, 0, 0);
      run_vec(t, y, lat);
      total++;
      if (y !== 100 || lat != 5) $display("FAIL single_tap0: got %0d lat %0d, want 100 lat 5", y, lat);
      else passed++;
      set_all(0, 0, 0, 4096, 0);
      run_vec(t, y, lat);
      total++;
      if (y !== 400 || lat != 5) $display("FAIL single_tap3: got %0d lat %0d, want 400 lat 5", y, lat);
      else passed++;
   endtask

   task automatic test_half_weights();
      int t [4];
      int y, lat;
      t = '{4096, 4096, 4096, 4096};
      set_all(2048, 2048, 2048, 2048, 4096);
      run_vec(t, y, lat);
      total++;
      if (y !== 12288 || lat != 5) $display("FAIL half_weights: got %0d lat %0d, want 12288 lat 5", y, lat);
      else passed++;
   endtask

   task automatic test_saturation();
      int t [4];
      int y, lat;
      set_all(32767, 32767, 32767, 32767, 0);
      t = '{32767, 32767, 32767, 32767};
      run_vec(t, y, lat);
      total++;
      if (y !== 32767) $display("FAIL sat_pos: got %0d want 32767", y);
      else passed++;
      t = '{-32768, -32768, -32768, -32768};
      run_vec(t, y, lat);
      total++;
      if (y !== -32768) $display("FAIL sat_neg: got %0d want -32768", y);
      else passed++;
   endtask

   task automatic test_rounding();
      int t [4];
      int y, lat;
      int tap0 [4];
      int want [4];
      tap0 = '{2048, 2047, -2048, -2049};
      want = '{1, 0, 0, -1};
      set_all(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         t = '{tap0[i], 0, 0, 0};
         run_vec(t, y, lat);
         total++;
         if (y !== want[i]) $display("FAIL rounding tap0=%0d: got %0d want %0d", tap0[i], y, want[i]);
         else passed++;
      end
   endtask

   task automatic test_random();
      int t [4];
      int y, lat, exp_y;
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 2))
            0: for (int a = 0; a < 5; a++) set_w(a, rnd16());
            1: for (int a = 0; a < 5; a++) set_w(a, int'($urandom_range(0, 8192)) - 4096);
            default: set_w(int'($urandom_range(5, 7)), rnd16());
         endcase
         for (int k = 0; k < 4; k++) t[k] = rnd16();
         exp_y = ref_y(t);
         run_vec(t, y, lat);
         total++;
         if (y !== exp_y || lat != 5) $display("FAIL random[%0d]: got %0d lat %0d, want %0d lat 5", i, y, lat, exp_y);
         else passed++;
      end
   endtask

   task automatic test_backpressure();
      int t [4];
      int lat, exp_y;
      set_all(1234, -2222, 3000, 777, -100);
      for (int k = 0; k < 4; k++) t[k] = int'($urandom_range(0, 8000)) - 4000;
      exp_y = ref_y(t);
      start_vec(t);
      wait_out(lat);
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if (bus.out_valid !== 1'b1 || int'($signed(bus.out_data)) !== exp_y || bus.in_ready !== 1'b0)
            $display("FAIL hold[%0d]: valid %b data %0d in_ready %b, want 1 %0d 0",
                     i, bus.out_valid, $signed(bus.out_data), bus.in_ready, exp_y);
         else passed++;
      end
      accept();
      total++;
      if (bus.out_valid !== 1'b0 || int'($signed(bus.out_data)) !== exp_y)
         $display("FAIL after_accept: valid %b data %0d, want 0 %0d", bus.out_valid, $signed(bus.out_data), exp_y);
      else passed++;
   endtask

   task automatic test_write_during_mac();
      int t [4];
      int y, lat;
      set_all(4096, 0, 0, 0, 0);
      t = '{100, 200, 300, 400};
      start_vec(t);
      tick();
      bus.w_wr_en = 1'b1;
      bus.w_addr  = 3'd0;
      bus.w_data  = 16'sd8192;
      tick();
      bus.w_wr_en = 1'b0;
      wait_out(lat);
      y = int'($signed(bus.out_data));
      accept();
      total++;
      if (y !== 100) $display("FAIL write_in_mac: got %0d want 100", y);
      else passed++;
      run_vec(t, y, lat);
      total++;
      if (y !== 100) $display("FAIL write_in_mac_kept: got %0d want 100", y);
      else passed++;
   endtask

   task automatic test_rst_mid_mac();
      int t [4];
      int y, lat;
      bit seen;
      set_all(4096, 4096, 4096, 4096, 4096);
      t = '{500, 600, 700, 800};
      start_vec(t);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mw = '{0, 0, 0, 0};
      mb = 0;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL rst_mid_mac: in_ready %b out_valid %b, want 1 0", bus.in_ready, bus.out_valid);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid) seen = 1'b1;
         tick();
      end
      total++;
      if (seen) $display("FAIL rst_no_emit: got out_valid 1 want 0");
      else passed++;
      set_w(2, 4096);
      run_vec(t, y, lat);
      total++;
      if (y !== ref_y(t) || lat != 5) $display("FAIL rst_recover: got %0d lat %0d, want %0d lat 5", y, lat, ref_y(t));
      else passed++;
   endtask

   task automatic test_back_to_back();
      int cur [4];
      int expq [$];
      int times [$];
      int accepted, got;
      bit acc_now;
      set_all(int'($urandom_range(0, 8192)) - 4096, int'($urandom_range(0, 8192)) - 4096,
              int'($urandom_range(0, 8192)) - 4096, int'($urandom_range(0, 8192)) - 4096, rnd16());
      for (int k = 0; k < 4; k++) begin cur[k] = rnd16(); bus.taps[k] = 16'(cur[k]); end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      accepted = 0;
      got = 0;
      for (int c = 0; c < 80 && got < 4; c++) begin
         if (bus.out_valid) begin
            total++;
            if (expq.size() == 0 || int'($signed(bus.out_data)) !== expq[0])
               $display("FAIL b2b_data[%0d]: got %0d want %0d", got, $signed(bus.out_data),
                        (expq.size() == 0) ? 0 : expq[0]);
            else passed++;
            if (expq.size() != 0) void'(expq.pop_front());
            got++;
         end
         acc_now = bus.in_valid && bus.in_ready;
         if (acc_now) begin
            expq.push_back(ref_y(cur));
            times.push_back(c);
            accepted++;
         end
         tick();
         if (acc_now) begin
            if (accepted == 4) bus.in_valid = 1'b0;
            else for (int k = 0; k < 4; k++) begin cur[k] = rnd16(); bus.taps[k] = 16'(cur[k]); end
         end
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      total++;
      if (got != 4) $display("FAIL b2b_count: got %0d results want 4", got);
      else passed++;
      // IDLE, four MAC cycles, ROUND and OUT: a new vector is taken every 7th edge.
      for (int i = 1; i < times.size(); i++) begin
         total++;
         if (times[i] - times[i-1] != 7)
            $display("FAIL b2b_interval[%0d]: got %0d want 7", i, times[i] - times[i-1]);
         else passed++;
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.taps     = '0;
      bus.in_valid = 1'b0;
      bus.w_wr_en  = 1'b0;
      bus.w_addr   = '0;
      bus.w_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_zero_weights();
      test_single_tap();
      test_half_weights();
      test_saturation();
      test_rounding();
      test_random();
      test_backpressure();
      test_write_during_mac();
      test_rst_mid_mac();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
      $fatal(1);
   end
endmodule
